// File: rtl/bigint_mult_n_if.sv
// Command, operand-RAM read and result-RAM write signals of bigint_mult_n.
// The multiplier sits on the slave modport; the requester/RAM side uses master.
interface bigint_mult_n_if #(
    parameter int WORD_W = 64,
    parameter int LIMBS  = 32,
    parameter int AW     = (LIMBS > 1) ? $clog2(LIMBS) : 1
);
    logic              start;
    logic [AW:0]       len;
    logic              lowOnly;
    logic [AW-1:0]     aAddr;
    logic [WORD_W-1:0] aData;
    logic [AW-1:0]     bAddr;
    logic [WORD_W-1:0] bData;
    logic [AW:0]       rAddr;
    logic [WORD_W-1:0] rData;
    logic              rWen;
    logic              busy;
    logic              done;

    modport master (
        output start, len, lowOnly, aData, bData,
        input  aAddr, bAddr, rAddr, rData, rWen, busy, done
    );

    modport slave (
        input  start, len, lowOnly, aData, bData,
        output aAddr, bAddr, rAddr, rData, rWen, busy, done
    );
endinterface

// File: rtl/bigint_mult_n.sv
// Product-scanning schoolbook big-integer multiplier: one limb pair per cycle,
// one result limb streamed per column, optional truncated low-half mode.
module bigint_mult_n #(
    parameter int WORD_W = 64,
    parameter int LIMBS  = 32,
    parameter int AW     = (LIMBS > 1) ? $clog2(LIMBS) : 1
) (
    input  logic           clk,
    input  logic           reset,
    bigint_mult_n_if.slave bus
);
    localparam int ACC_W = 2 * WORD_W + AW + 1;

    localparam logic [AW:0]   LIMBS_N = (AW + 1)'(LIMBS);
    localparam logic [AW:0]   ONE     = (AW + 1)'(1);
    localparam logic [AW:0]   TWO     = (AW + 1)'(2);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN1,
        DRAIN2,
        WRITE,
        FINAL,
        DONE
    } state_t;

    state_t state;

    logic [AW:0]   n;
    logic          low;
    logic [AW:0]   k;
    logic [AW-1:0] i_hi;

    logic                vld1;
    logic                vld2;
    logic [2*WORD_W-1:0] p;
    logic [ACC_W-1:0]    acc;

    logic [AW:0]         n_in;
    logic [AW:0]         n_sel;
    logic [AW:0]         k_nx;
    logic [AW-1:0]       col_lo;
    logic [AW-1:0]       col_hi;
    logic [AW-1:0]       b_first;
    logic [AW:0]         last_k;
    logic [ACC_W-1:0]    acc_nxt;
    logic [2*WORD_W-1:0] a_ext;
    logic [2*WORD_W-1:0] b_ext;

    // Bounds of the next column are precomputed so the address registers can
    // already hold the first pair when ISSUE is entered.
    always_comb begin
        n_in    = (bus.len == '0 || bus.len > LIMBS_N) ? LIMBS_N : bus.len;
        n_sel   = (state == IDLE) ? n_in : n;
        k_nx    = (state == IDLE) ? '0 : k + ONE;
        col_lo  = (k_nx >= n_sel) ? AW'(k_nx - n_sel + ONE) : '0;
        col_hi  = (k_nx < n_sel) ? AW'(k_nx) : AW'(n_sel - ONE);
        b_first = AW'(k_nx - {1'b0, col_lo});
        last_k  = low ? n - ONE : (n << 1) - TWO;
        a_ext   = {{WORD_W{1'b0}}, bus.aData};
        b_ext   = {{WORD_W{1'b0}}, bus.bData};
        if (state == WRITE) begin
            acc_nxt = acc >> WORD_W;
        end else if (vld2) begin
            acc_nxt = acc + {{(AW + 1){1'b0}}, p};
        end else begin
            acc_nxt = acc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld1 <= 1'b0;
            vld2 <= 1'b0;
            p    <= '0;
            acc  <= '0;
        end else begin
            vld1 <= (state == ISSUE);
            vld2 <= vld1;
            p    <= vld1 ? a_ext * b_ext : '0;
            acc  <= (state == IDLE && bus.start) ? '0 : acc_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            n         <= '0;
            low       <= 1'b0;
            k         <= '0;
            i_hi      <= '0;
            bus.aAddr <= '0;
            bus.bAddr <= '0;
            bus.rAddr <= '0;
            bus.rData <= '0;
            bus.rWen  <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n         <= n_in;
                        low       <= bus.lowOnly;
                        k         <= '0;
                        bus.aAddr <= col_lo;
                        bus.bAddr <= b_first;
                        i_hi      <= col_hi;
                        bus.busy  <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.aAddr == i_hi) begin
                        bus.aAddr <= '0;
                        bus.bAddr <= '0;
                        state     <= DRAIN1;
                    end else begin
                        bus.aAddr <= bus.aAddr + ONE_A;
                        bus.bAddr <= bus.bAddr - ONE_A;
                    end
                end
                DRAIN1: state <= DRAIN2;
                DRAIN2: begin
                    // acc_nxt already includes the last product of this column.
                    bus.rWen  <= 1'b1;
                    bus.rAddr <= k;
                    bus.rData <= acc_nxt[WORD_W-1:0];
                    state     <= WRITE;
                end
                WRITE: begin
                    if (k == last_k && !low) begin
                        bus.rWen  <= 1'b1;
                        bus.rAddr <= k + ONE;
                        bus.rData <= acc_nxt[WORD_W-1:0];
                        state     <= FINAL;
                    end else begin
                        bus.rWen  <= 1'b0;
                        bus.rAddr <= '0;
                        bus.rData <= '0;
                        if (k == last_k) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            k         <= k_nx;
                            bus.aAddr <= col_lo;
                            bus.bAddr <= b_first;
                            i_hi      <= col_hi;
                            state     <= ISSUE;
                        end
                    end
                end
                FINAL: begin
                    bus.rWen  <= 1'b0;
                    bus.rAddr <= '0;
                    bus.rData <= '0;
                    bus.busy  <= 1'b0;
                    bus.done  <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bigint_mult_n.sv
// Scoreboard bench for bigint_mult_n: expected result-RAM writes are queued at
// issue time and a negedge monitor checks every write against the queue.
module tb_bigint_mult_n;
    localparam int W  = 64;
    localparam int L  = 4;
    localparam int AW = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    bigint_mult_n_if #(.WORD_W(W), .LIMBS(L)) bus ();

    bigint_mult_n #(.WORD_W(W), .LIMBS(L)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] a_mem [L];
    logic [W-1:0] b_mem [L];

    always @(posedge clk) begin
        bus.aData <= a_mem[bus.aAddr];
        bus.bData <= b_mem[bus.bAddr];
    end

    typedef struct {
        int           addr;
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int start_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        compared++;
        if (bus.rWen) begin
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                         bus.rAddr, bus.rData);
            end else begin
                e = sb.pop_front();
                if (int'(bus.rAddr) != e.addr || bus.rData !== e.data ||
                    (e.cyc >= 0 && (cyc - start_cyc) != e.cyc)) begin
                    mismatched++;
                    $display("FAIL write: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                             bus.rAddr, bus.rData, cyc - start_cyc, e.addr, e.data, e.cyc);
                end
            end
        end else if (bus.rAddr != '0 || bus.rData != '0) begin
            mismatched++;
            $display("FAIL idle_outputs: got rAddr=%0d rData=%h, required 0", bus.rAddr, bus.rData);
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input int addr, input logic [W-1:0] data, input int c);
        exp_t e;
        e.addr = addr;
        e.data = data;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic push_golden(input int n, input int count);
        logic [4*W-1:0] a_v;
        logic [4*W-1:0] b_v;
        logic [8*W-1:0] prod;
        a_v = '0;
        b_v = '0;
        for (int j = 0; j < n; j++) begin
            a_v[j*W +: W] = a_mem[j];
            b_v[j*W +: W] = b_mem[j];
        end
        prod = {{(4*W){1'b0}}, a_v} * {{(4*W){1'b0}}, b_v};
        for (int j = 0; j < count; j++) push(j, prod[j*W +: W], -1);
    endtask

    task automatic randomize_mems();
        for (int j = 0; j < L; j++) begin
            a_mem[j] = {$urandom, $urandom};
            b_mem[j] = {$urandom, $urandom};
        end
    endtask

    task automatic run(input logic [AW:0] len_v, input logic low, input int exp_done, input int glitch);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.len     = len_v;
        bus.lowOnly = low;
        start_cyc   = cyc;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.len     = 3'd1;
        bus.lowOnly = ~low;
        while (!bus.done && (cyc - start_cyc) < 200) begin
            check("busy", {63'd0, bus.busy}, 64'd1);
            bus.start = ((cyc - start_cyc) == glitch);
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("done_cycle", cyc - start_cyc, exp_done);
        check("busy_at_done", {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.len     = '0;
        bus.lowOnly = 1'b0;
        for (int j = 0; j < L; j++) begin
            a_mem[j] = '0;
            b_mem[j] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_ctrl", {54'd0, bus.aAddr, bus.bAddr, bus.rAddr, bus.rWen, bus.busy, bus.done}, 64'd0);
        check("reset_rdata", bus.rData, 64'd0);
        reset = 1'b1;

        // 3 * 5 with a single limb
        a_mem[0] = 64'd3;
        b_mem[0] = 64'd5;
        push(0, 64'd15, 4);
        push(1, 64'd0, 5);
        run(3'd1, 1'b0, 6, -1);

        // (2^128-1)^2 = 2^256 - 2^129 + 1
        a_mem[0] = '1; a_mem[1] = '1;
        b_mem[0] = '1; b_mem[1] = '1;
        push(0, 64'd1, 4);
        push(1, 64'd0, 9);
        push(2, 64'hFFFF_FFFF_FFFF_FFFE, 13);
        push(3, 64'hFFFF_FFFF_FFFF_FFFF, 14);
        run(3'd2, 1'b0, 15, -1);

        push(0, 64'd1, 4);
        push(1, 64'd0, 9);
        run(3'd2, 1'b1, 10, -1);

        // stray start (with len=1) in cycle 5 must be ignored
        push(0, 64'd1, 4);
        push(1, 64'd0, 9);
        push(2, 64'hFFFF_FFFF_FFFF_FFFE, 13);
        push(3, 64'hFFFF_FFFF_FFFF_FFFF, 14);
        run(3'd2, 1'b0, 15, 5);

        // len above LIMBS saturates to LIMBS
        randomize_mems();
        push_golden(4, 8);
        run(3'd5, 1'b0, 39, -1);

        randomize_mems();
        push_golden(3, 6);
        run(3'd3, 1'b0, 26, -1);
        push_golden(3, 3);
        run(3'd3, 1'b1, 16, -1);

        for (int t = 0; t < 100; t++) begin
            randomize_mems();
            push_golden(4, 8);
            run(3'd0, 1'b0, 39, -1);
            push_golden(4, 4);
            run(3'd0, 1'b1, 23, -1);
        end

        // reset during ISSUE of column 3 (cycles 16..19 for n=4)
        randomize_mems();
        push_golden(4, 3);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.len     = 3'd0;
        bus.lowOnly = 1'b0;
        start_cyc   = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        while ((cyc - start_cyc) < 17) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_mid_ctrl", {54'd0, bus.aAddr, bus.bAddr, bus.rAddr, bus.rWen, bus.busy, bus.done}, 64'd0);
        check("reset_mid_rdata", bus.rData, 64'd0);
        repeat (3) @(negedge clk);
        check("sb_after_reset", sb.size(), 64'd0);
        reset = 1'b1;

        push_golden(4, 8);
        run(3'd4, 1'b0, 39, -1);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/bigint_mult_n.md
# bigint_mult_n

Parametrised big-integer multiplier for the RSA datapath. It computes the product of two multi-limb operands held in external synchronous RAMs, one limb per cycle, using column-wise (product-scanning) schoolbook multiplication. Each result limb is streamed into an external result RAM. It replaces the fixed 64-bit/64-entry multiplier with configurable limb width and limb count, a runtime operand length, and a truncated low-half mode for Montgomery reduction.

## Interface
Parameters:
- `WORD_W`, 64: limb width in bits.
- `LIMBS`, 32: maximum operand length in limbs; must be ≥1.
- `AW`, `$clog2(LIMBS)` (min 1): operand address width.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `len` in AW+1: active limb count n, sampled with `start`; 0 or >LIMBS means LIMBS.
- `lowOnly` in 1: sampled with `start`; 1 computes limbs 0..n-1 only (product mod 2^(n·WORD_W)).
- `aAddr` out AW: A RAM read address.
- `aData` in WORD_W: A RAM data, valid the cycle after `aAddr`.
- `bAddr` out AW: B RAM read address.
- `bData` in WORD_W: B RAM data, valid the cycle after `bAddr`.
- `rAddr` out AW+1: result RAM write address.
- `rData` out WORD_W: result write data.
- `rWen` out 1: result write enable.
- `busy` out 1: high from the cycle after `start` until `done`.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, ISSUE, DRAIN1, DRAIN2, WRITE, FINAL, DONE.
- IDLE: on `start`, latch n and `lowOnly`, clear the accumulator, set column k=0, and go to ISSUE.
- ISSUE: for column k, step i from max(0,k-n+1) up to min(k,n-1), one pair per cycle.
  - Drive `aAddr`=i and `bAddr`=k-i.
  - After the last pair, go to DRAIN1.
- Pipeline: data returns in cycle t+1. Product register p ≤ aData·bData (2·WORD_W) at the end of t+1. Accumulator acc += p at the end of t+2.
- DRAIN1 → DRAIN2 → WRITE.
- WRITE: assert `rWen`=1, `rAddr`=k, `rData`=acc[WORD_W-1:0]. Then acc ≤ acc >> WORD_W.
  - If the last column is done, go to FINAL (full mode) or DONE (lowOnly).
  - Otherwise k++ and return to ISSUE.
  - The last column is 2n-2 in full mode and n-1 in lowOnly.
- FINAL: write `rAddr`=2n-1 with `rData`=acc[WORD_W-1:0], then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Accumulator width is 2·WORD_W + AW + 1, which is overflow-free for n ≤ LIMBS. Its residue after FINAL is zero.
- `start` while not in IDLE is ignored. `len`/`lowOnly` changes after sampling have no effect.
- Outputs when not active: `aAddr`/`bAddr` are 0 outside ISSUE. `rAddr`/`rData` are 0 whenever `rWen`=0.
- Every result address is written exactly once per operation: 0..2n-1 in full mode, 0..n-1 in lowOnly.

## Timing
- Reset (async assert, any state): IDLE, all outputs 0, acc/p cleared, no write in that cycle or after. Sync deassert assumed from the reset tree.
- Column k costs c_k + 3 cycles, where c_k is the pair count: issue, two drain cycles, one write.
- Full mode, `start` at cycle 0: work spans cycles 1..n²+6n-2, and `done` is asserted at cycle n²+6n-1.
- lowOnly: work spans cycles 1..n(n+1)/2+3n, and `done` is asserted at cycle n(n+1)/2+3n+1.
- `busy` is high in cycles 1..done-1 and low in the `done` cycle. A new `start` is accepted in the cycle after `done`.
- The RAM read latency is exactly 1. Columns do not overlap.

## Test plan
- WORD_W=64, n=1, A=3, B=5, full: writes r[0]=15 at cycle 4 and r[1]=0 at cycle 5; `done` at cycle 6.
- n=2, A=B=2^128-1, full:
  - Writes r0=1, r1=0, r2=0xFFFF_FFFF_FFFF_FFFE, r3=0xFFFF_FFFF_FFFF_FFFF.
  - `done` at cycle 15.
- Same operands, lowOnly=1: writes only r0=1 and r1=0; `done` at cycle 10; no write to addresses ≥2.
- `len`=0 with LIMBS=4, 100 random operand pairs, both modes: results match the golden model, and each address is written once.
- Assert `reset` low mid-ISSUE of column 3: outputs are 0 immediately and no further `rWen`. A following `start` yields a correct result.
- Pulse `start` during busy with different `len`: ignored, and the current result and latency are unchanged.
